// File: rtl/dcache_mem_stage_if.sv
// Single-word memory bus between the data cache (master) and main memory (slave).
// Handshake: mem_req rises with mem_addr/mem_we/mem_wdata/mem_be, all held stable until the
// cycle mem_ack is high; ack may come in the same cycle req rises and is ignored while req is low.
interface dcache_mem_stage_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_be;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dcache_mem_stage.sv
// Direct-mapped, write-through, no-write-allocate data cache for the memory stage.
// Load hits answer in the issue cycle; misses refill a whole line word by word from word 0.
module dcache_mem_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SETS           = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [3:0]            req_be_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  resp_valid_o,
  output logic                  stall_o,
  dcache_mem_stage_if.master    mem,
  output logic [1:0]            state_dbg
);
  localparam int WORD_W = $clog2(WORDS_PER_LINE);
  localparam int OFF_W  = WORD_W + 2;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, STORE = 2'd2, DONE = 2'd3} state_t;

  state_t              state_q;
  logic [WORD_W-1:0]   cnt_q;
  logic [SETS-1:0]     valid_q;
  logic [TAG_W-1:0]    tag_q  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS][WORDS_PER_LINE];

  logic [TAG_W-1:0]      req_tag;
  logic [IDX_W-1:0]      req_idx;
  logic [WORD_W-1:0]     req_word;
  logic                  hit;
  logic [DATA_WIDTH-1:0] cur_word;
  logic [DATA_WIDTH-1:0] merged;
  logic                  unused_addr_bits;

  assign req_tag          = req_addr_i[ADDR_WIDTH-1 -: TAG_W];
  assign req_idx          = req_addr_i[OFF_W +: IDX_W];
  assign req_word         = req_addr_i[2 +: WORD_W];
  assign hit              = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign cur_word         = data_q[req_idx][req_word];
  assign unused_addr_bits = ^req_addr_i[1:0];
  assign state_dbg        = state_q;

  // Store data merged lane by lane into the cached word, used only on a store hit.
  always_comb begin
    merged = cur_word;
    for (int b = 0; b < 4; b++) begin
      if (req_be_i[b]) merged[8*b +: 8] = req_wdata_i[8*b +: 8];
    end
  end

  always_comb begin
    stall_o        = 1'b0;
    resp_valid_o   = 1'b0;
    rdata_o        = '0;
    mem.mem_req    = 1'b0;
    mem.mem_we     = 1'b0;
    mem.mem_addr   = '0;
    mem.mem_wdata  = '0;
    mem.mem_be     = 4'b0000;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (!req_we_i && hit) begin
            resp_valid_o = 1'b1;
            rdata_o      = cur_word;
          end else begin
            stall_o = 1'b1;
          end
        end
      end
      FILL: begin
        stall_o      = 1'b1;
        mem.mem_req  = 1'b1;
        mem.mem_addr = {req_tag, req_idx, cnt_q, 2'b00};
      end
      STORE: begin
        stall_o       = 1'b1;
        mem.mem_req   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
        mem.mem_wdata = req_wdata_i;
        mem.mem_be    = req_be_i;
      end
      DONE: begin
        resp_valid_o = 1'b1;
        if (!req_we_i) rdata_o = cur_word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            if (req_we_i) begin
              state_q <= STORE;
            end else if (!hit) begin
              state_q <= FILL;
              cnt_q   <= '0;
            end
          end
        end
        FILL: begin
          if (mem.mem_ack) begin
            cnt_q <= cnt_q + 1'b1;
            // The line only becomes visible once every word has landed.
            if (cnt_q == LAST_WORD) begin
              valid_q[req_idx] <= 1'b1;
              state_q          <= DONE;
            end
          end
        end
        STORE: begin
          if (mem.mem_ack) state_q <= DONE;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag and data storage carry no reset; validity alone qualifies them.
  always_ff @(posedge clk) begin
    if (!rst && mem.mem_ack) begin
      if (state_q == FILL) begin
        data_q[req_idx][cnt_q] <= mem.mem_rdata;
        if (cnt_q == LAST_WORD) tag_q[req_idx] <= req_tag;
      end else if (state_q == STORE && hit) begin
        data_q[req_idx][req_word] <= merged;
      end
    end
  end
endmodule
